exec_writeback_unit: RTL and testbench
======================================

EXEC_WRITEBACK_UNIT -- requirements
Module: exec_writeback_unit

Interface
REQ-001 Parameter DATA_W, default 16: operand/result width, must be at least 8.
REQ-002 Parameter REG_AW, default 4: register-file address width.
REQ-003 Parameter MEM_AW, default 8: data-memory address width.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Ports in_valid input 1 / in_ready output 1: issue handshake; an instruction is accepted on a cycle where both are 1.
REQ-007 Ports opcode input 4, dest_reg input REG_AW, src_val1/src_val2 input DATA_W, mem_addr input MEM_AW: instruction fields.
REQ-008 Ports fwd1/fwd2, input, 1: when 1, replace src_val1/src_val2 with the internal last_result register.
REQ-009 Ports wb_en output 1, wb_reg output REG_AW, wb_val output DATA_W: register-file write request.
REQ-010 Ports mem_addr_out output MEM_AW, mem_wdata output DATA_W, mem_we output 1, mem_re output 1: memory request.
REQ-011 Ports mem_rdata input DATA_W, mem_rvalid input 1: load response.
REQ-012 Port psw, output, 5: {C,V,Z,N,ILL} status flags, bit 4 = C.
REQ-013 Port powerdown, output, 1: halted indicator.

Function
REQ-014 Opcodes SHALL be: 0 NOP, 1 HLT, 2 ADD, 3 SUB, 4 MUL, 5 SHL, 6 SHR, 7 AND, 8 OR, 9 NOT (op1 only), 10 XOR, 14 LOAD, 15 STORE; 11-13 illegal.
REQ-015 FSM states SHALL be IDLE, LOAD_WAIT, HALTED; in_ready=1 only in IDLE.
REQ-016 ALU ops (2-10) accepted in IDLE SHALL drive wb_en=1 for exactly one cycle on the next cycle, with wb_reg=dest_reg and wb_val=result.
REQ-017 Every wb_en=1 cycle SHALL also load wb_val into last_result, so forwarding sees the most recent writeback, including loads.
REQ-018 ADD: C = carry out of bit DATA_W-1; V = operands share sign and result sign differs.
REQ-019 SUB (op1-op2): C = borrow; V = operand signs differ and result sign differs from op1.
REQ-020 MUL: result = low DATA_W bits of the unsigned product; C = any upper-half bit set; V = C.
REQ-021 SHL/SHR: amount = op2 unsigned; amount >= DATA_W yields result 0; C = last bit shifted out (0 if amount is 0); V = 0.
REQ-022 AND/OR/NOT/XOR SHALL clear C and V.
REQ-023 Z and N SHALL reflect wb_val on every writeback; psw SHALL hold its value on NOP/STORE cycles; ILL is sticky until reset.
REQ-024 LOAD SHALL set mem_addr_out=mem_addr, raise mem_re the next cycle, and enter LOAD_WAIT.
REQ-025 mem_re SHALL stay 1 until the cycle mem_rvalid=1 is sampled.
REQ-026 On that cycle, mem_rdata SHALL be captured; on the next cycle wb_en=1, wb_val=captured data, Z/N updated, C/V unchanged, and the FSM returns to IDLE.
REQ-027 mem_rvalid outside LOAD_WAIT SHALL be ignored.
REQ-028 STORE SHALL pulse mem_we=1 for one cycle on the next cycle, with mem_addr_out=mem_addr and mem_wdata=op1 after forwarding; no writeback.
REQ-029 HLT SHALL enter HALTED and set powerdown=1; only rst leaves HALTED.
REQ-030 An illegal opcode SHALL set ILL and produce no writeback or memory request.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE and drive every output to 0, except in_ready=1.
REQ-032 rst=1 SHALL also clear last_result and psw.
REQ-033 Reset during LOAD_WAIT SHALL drop mem_re at once and discard any pending response.

Verification
REQ-034 DATA_W=16, ADD 0x7FFF+0x0001 -> wb_val=0x8000, V=1, N=1, C=0, Z=0, one cycle after accept.
REQ-035 SUB 0x0000-0x0001, then ADD with fwd1=1, src_val2=1 -> second wb_val=0x0000, Z=1, C=1.
REQ-036 LOAD addr 0x21, mem_rvalid after 3 cycles with 0x00A5 -> mem_re high for exactly 3 cycles, in_ready=0 throughout, wb_val=0x00A5 on the following cycle.
REQ-037 SHL 0x8001 by 16 -> 0x0000, Z=1; SHL 0x8001 by 1 -> 0x0002, C=1.
REQ-038 HLT, then in_valid held high with ADD -> powerdown=1, in_ready=0, no wb_en; rst pulse -> all outputs 0, in_ready=1.
REQ-039 DATA_W=32 build, MUL 0x00010000*0x00010000 -> wb_val=0, C=1, V=1, Z=1.

Source files
------------

// File: rtl/exec_writeback_unit.sv
// exec_writeback_unit: single-issue execute/writeback stage with ALU, load/store
// requests, status flags and halt, using operand forwarding from the last writeback.
module exec_writeback_unit #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int MEM_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        opcode,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic [DATA_W-1:0] src_val1,
   input  logic [DATA_W-1:0] src_val2,
   input  logic [MEM_AW-1:0] mem_addr,
   input  logic              fwd1,
   input  logic              fwd2,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_reg,
   output logic [DATA_W-1:0] wb_val,
   output logic [MEM_AW-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [4:0]        psw,
   output logic              powerdown
);
   typedef enum logic [1:0] {IDLE, LOAD_WAIT, HALTED} state_t;
   state_t state_q, state_d;
   logic              wb_en_q, wb_en_d, mem_we_q, mem_we_d;
   logic [REG_AW-1:0] wb_reg_q, wb_reg_d;
   logic [DATA_W-1:0] wb_val_q, wb_val_d, mem_wdata_q, mem_wdata_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [4:0]        psw_q, psw_d;
   logic [DATA_W-1:0] op1, op2, res;
   logic [DATA_W:0]   sum, diff, shl_t, shr_t;
   logic [2*DATA_W-1:0] prod;
   logic              c, v, accept;
   // wb_val only changes on writeback, so it doubles as the forwarding register
   assign op1    = fwd1 ? wb_val_q : src_val1;
   assign op2    = fwd2 ? wb_val_q : src_val2;
   assign sum    = {1'b0, op1} + {1'b0, op2};
   assign diff   = {1'b0, op1} - {1'b0, op2};
   assign prod   = {{DATA_W{1'b0}}, op1} * {{DATA_W{1'b0}}, op2};
   assign shl_t  = {1'b0, op1} << op2;
   assign shr_t  = {op1, 1'b0} >> op2;
   assign accept = in_valid && state_q == IDLE;
   always_comb begin
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (opcode)
         4'd2: begin
            res = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            v   = (op1[DATA_W-1] == op2[DATA_W-1]) && (res[DATA_W-1] != op1[DATA_W-1]);
         end
         4'd3: begin
            res = diff[DATA_W-1:0];
            c   = diff[DATA_W];
            v   = (op1[DATA_W-1] != op2[DATA_W-1]) && (res[DATA_W-1] != op1[DATA_W-1]);
         end
         4'd4: begin
            res = prod[DATA_W-1:0];
            c   = |prod[2*DATA_W-1:DATA_W];
            v   = c;
         end
         4'd5: begin
            res = shl_t[DATA_W-1:0];
            c   = shl_t[DATA_W];
         end
         4'd6: begin
            res = shr_t[DATA_W:1];
            c   = shr_t[0];
         end
         4'd7:    res = op1 & op2;
         4'd8:    res = op1 | op2;
         4'd9:    res = ~op1;
         4'd10:   res = op1 ^ op2;
         default: res = '0;
      endcase
   end
   always_comb begin
      state_d     = state_q;
      wb_en_d     = 1'b0;
      wb_reg_d    = wb_reg_q;
      wb_val_d    = wb_val_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      psw_d       = psw_q;
      if (state_q == LOAD_WAIT && mem_rvalid) begin
         state_d  = IDLE;
         wb_en_d  = 1'b1;
         wb_val_d = mem_rdata;
         psw_d    = {psw_q[4:3], ~|mem_rdata, mem_rdata[DATA_W-1], psw_q[0]};
      end else if (accept) begin
         if (opcode inside {[4'd2:4'd10]}) begin
            wb_en_d  = 1'b1;
            wb_reg_d = dest_reg;
            wb_val_d = res;
            psw_d    = {c, v, ~|res, res[DATA_W-1], psw_q[0]};
         end else if (opcode == 4'd1) begin
            state_d = HALTED;
         end else if (opcode == 4'd14) begin
            state_d    = LOAD_WAIT;
            mem_addr_d = mem_addr;
            wb_reg_d   = dest_reg;
         end else if (opcode == 4'd15) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = mem_addr;
            mem_wdata_d = op1;
         end else if (opcode != 4'd0) begin
            psw_d[0] = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wb_en_q     <= 1'b0;
         wb_reg_q    <= '0;
         wb_val_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         psw_q       <= '0;
      end else begin
         state_q     <= state_d;
         wb_en_q     <= wb_en_d;
         wb_reg_q    <= wb_reg_d;
         wb_val_q    <= wb_val_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         psw_q       <= psw_d;
      end
   end
   assign in_ready     = state_q == IDLE;
   assign mem_re       = state_q == LOAD_WAIT;
   assign powerdown    = state_q == HALTED;
   assign wb_en        = wb_en_q;
   assign wb_reg       = wb_reg_q;
   assign wb_val       = wb_val_q;
   assign mem_addr_out = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_we       = mem_we_q;
   assign psw          = psw_q;
endmodule

// File: tb/tb_exec_writeback_unit.sv
// tb_exec_writeback_unit: directed and randomized checks of exec_writeback_unit
// against an arithmetic reference model of the instruction rules.
module tb_exec_writeback_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_ready, fwd1 = 1'b0, fwd2 = 1'b0;
   logic [3:0]  opcode = '0, dest_reg = '0;
   logic [15:0] src_val1 = '0, src_val2 = '0, wb_val, mem_wdata, mem_rdata = '0;
   logic [7:0]  mem_addr = '0, mem_addr_out;
   logic wb_en, mem_we, mem_re, mem_rvalid = 1'b0, powerdown;
   logic [3:0]  wb_reg;
   logic [4:0]  psw;
   logic p_in_valid = 1'b0, p_in_ready, p_wb_en, p_mem_we, p_mem_re, p_powerdown;
   logic [3:0]  p_opcode = '0, p_wb_reg;
   logic [31:0] p_src1 = '0, p_src2 = '0, p_wb_val, p_mem_wdata;
   logic [7:0]  p_mem_addr_out;
   logic [4:0]  p_psw;
   int checks = 0, failures = 0;
   logic [15:0] exp_last;
   logic [4:0]  exp_psw;

   always #5 clk = ~clk;

   exec_writeback_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .dest_reg(dest_reg), .src_val1(src_val1), .src_val2(src_val2), .mem_addr(mem_addr),
      .fwd1(fwd1), .fwd2(fwd2), .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
      .mem_addr_out(mem_addr_out), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .psw(psw), .powerdown(powerdown));

   exec_writeback_unit #(.DATA_W(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .opcode(p_opcode),
      .dest_reg(4'd1), .src_val1(p_src1), .src_val2(p_src2), .mem_addr(8'd0),
      .fwd1(1'b0), .fwd2(1'b0), .wb_en(p_wb_en), .wb_reg(p_wb_reg), .wb_val(p_wb_val),
      .mem_addr_out(p_mem_addr_out), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we),
      .mem_re(p_mem_re), .mem_rdata(32'd0), .mem_rvalid(1'b0), .psw(p_psw),
      .powerdown(p_powerdown));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [15:0] a,
                        input logic [15:0] b, input logic f1, input logic f2, input logic [7:0] ad);
      @(negedge clk);
      opcode = op; dest_reg = dst; src_val1 = a; src_val2 = b; fwd1 = f1; fwd2 = f2;
      mem_addr = ad; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Returns {C, V, result}; computed from signed/unsigned integer ranges and bitwise shifting.
   function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      longint ua = longint'(a), ub = longint'(b), full;
      longint sa = longint'($signed(a)), sb = longint'($signed(b)), s;
      logic [15:0] r = '0;
      logic cf = 1'b0, vf = 1'b0;
      case (op)
         4'd2: begin full = ua + ub; r = full[15:0]; cf = full > 65535; s = sa + sb; vf = s > 32767 || s < -32768; end
         4'd3: begin full = ua - ub; r = full[15:0]; cf = ua < ub; s = sa - sb; vf = s > 32767 || s < -32768; end
         4'd4: begin full = ua * ub; r = full[15:0]; cf = full > 65535; vf = cf; end
         4'd5: begin r = a; for (int i = 0; i < ub && i < 17; i++) begin cf = r[15]; r = r << 1; end end
         4'd6: begin r = a; for (int i = 0; i < ub && i < 17; i++) begin cf = r[0]; r = r >> 1; end end
         4'd7: r = a & b;
         4'd8: r = a | b;
         4'd9: r = ~a;
         4'd10: r = a ^ b;
         default: r = '0;
      endcase
      return {cf, vf, r};
   endfunction

   task automatic alu_step(input string tag, input logic [3:0] op, input logic [3:0] dst,
                           input logic [15:0] a, input logic [15:0] b, input logic f1, input logic f2);
      logic [17:0] m;
      m = model(op, f1 ? exp_last : a, f2 ? exp_last : b);
      issue(op, dst, a, b, f1, f2, 8'h00);
      exp_last = m[15:0];
      exp_psw = {m[17], m[16], m[15:0] == 16'h0, m[15], exp_psw[0]};
      chk({tag, ".wb_en"}, wb_en, 1'b1);
      chk({tag, ".wb_reg"}, wb_reg, dst);
      chk({tag, ".wb_val"}, wb_val, exp_last);
      chk({tag, ".psw"}, psw, exp_psw);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst.in_ready", in_ready, 1'b1);
      chk("rst.outs", {wb_en, wb_reg, wb_val, mem_addr_out, mem_wdata, mem_we, mem_re, psw, powerdown}, '0);
      @(negedge clk);
      rst = 1'b0;
      exp_last = '0;
      exp_psw = '0;
   endtask

   initial begin
      logic [3:0] op;
      logic [15:0] a, b;
      logic f1, f2;
      exp_last = '0;
      exp_psw = '0;
      #1;
      chk("reset.in_ready", in_ready, 1'b1);
      chk("reset.outs", {wb_en, wb_reg, wb_val, mem_addr_out, mem_wdata, mem_we, mem_re, psw, powerdown}, '0);
      @(negedge clk);
      rst = 1'b0;

      alu_step("add_ovf", 4'd2, 4'd3, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      chk("add_ovf.exact", {wb_val, psw}, {16'h8000, 5'b01010});
      tick();
      chk("wb_one_cycle", wb_en, 1'b0);

      alu_step("sub_borrow", 4'd3, 4'd1, 16'h0000, 16'h0001, 1'b0, 1'b0);
      alu_step("add_fwd", 4'd2, 4'd2, 16'h1234, 16'h0001, 1'b1, 1'b0);
      chk("add_fwd.exact", {wb_val, psw[4], psw[2]}, {16'h0000, 1'b1, 1'b1});

      alu_step("shl16", 4'd5, 4'd4, 16'h8001, 16'd16, 1'b0, 1'b0);
      chk("shl16.exact", {wb_val, psw[2]}, {16'h0000, 1'b1});
      alu_step("shl1", 4'd5, 4'd4, 16'h8001, 16'd1, 1'b0, 1'b0);
      chk("shl1.exact", {wb_val, psw[4]}, {16'h0002, 1'b1});
      alu_step("shr0", 4'd6, 4'd4, 16'h8001, 16'd0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(2, 10));
         a = 16'($urandom);
         b = (op == 4'd5 || op == 4'd6) ? 16'($urandom_range(0, 18)) : 16'($urandom);
         f1 = $urandom_range(0, 3) == 0;
         f2 = $urandom_range(0, 3) == 0;
         alu_step($sformatf("rand%0d_op%0d", i, op), op, 4'($urandom), a, b, f1, f2);
      end

      for (int i = 0; i < 5; i++) begin
         a = 16'($urandom);
         f1 = $urandom_range(0, 1) == 1;
         b = 16'($urandom_range(0, 255));
         issue(4'd15, 4'd0, a, 16'h0, f1, 1'b0, b[7:0]);
         chk("store.req", {mem_we, mem_addr_out, mem_wdata, wb_en}, {1'b1, b[7:0], f1 ? exp_last : a, 1'b0});
         chk("store.psw", psw, exp_psw);
         issue(4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 8'h00);
         chk("nop.quiet", {mem_we, wb_en, psw}, {1'b0, 1'b0, exp_psw});
      end

      issue(4'd12, 4'd1, 16'h1, 16'h1, 1'b0, 1'b0, 8'h00);
      exp_psw[0] = 1'b1;
      chk("ill.quiet", {wb_en, mem_we, mem_re, psw}, {3'b000, exp_psw});
      alu_step("ill_sticky", 4'd7, 4'd2, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);

      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
      tick();
      chk("rvalid_idle_ignored", {wb_en, wb_val}, {1'b0, exp_last});
      @(negedge clk);
      mem_rvalid = 1'b0;

      issue(4'd14, 4'd5, 16'h0, 16'h0, 1'b0, 1'b0, 8'h21);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("load.wait%0d", k), {mem_re, in_ready, wb_en, mem_addr_out}, {3'b100, 8'h21});
         @(negedge clk);
         if (k == 2) begin
            mem_rvalid = 1'b1; mem_rdata = 16'h00A5;
         end
         tick();
      end
      exp_last = 16'h00A5;
      exp_psw = {exp_psw[4:3], 2'b00, exp_psw[0]};
      chk("load.wb", {mem_re, in_ready, wb_en, wb_reg, wb_val}, {3'b011, 4'd5, 16'h00A5});
      chk("load.psw", psw, exp_psw);
      @(negedge clk);
      mem_rvalid = 1'b0;
      alu_step("load_fwd", 4'd2, 4'd6, 16'h0, 16'h0100, 1'b1, 1'b0);

      issue(4'd14, 4'd7, 16'h0, 16'h0, 1'b0, 1'b0, 8'h40);
      chk("load2.re", mem_re, 1'b1);
      reset_pulse();
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 16'h5555;
      tick();
      chk("load2.discard", {wb_en, mem_re, wb_val}, {2'b00, 16'h0});
      @(negedge clk);
      mem_rvalid = 1'b0;
      alu_step("post_rst_fwd", 4'd2, 4'd1, 16'h0, 16'h0003, 1'b1, 1'b0);

      issue(4'd1, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 8'h00);
      chk("hlt.state", {powerdown, in_ready}, 2'b10);
      @(negedge clk);
      opcode = 4'd2; src_val1 = 16'h1; src_val2 = 16'h1; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("halted%0d", k), {powerdown, in_ready, wb_en}, 3'b100);
      end
      @(negedge clk);
      in_valid = 1'b0;
      reset_pulse();

      @(negedge clk);
      p_opcode = 4'd4; p_src1 = 32'h0001_0000; p_src2 = 32'h0001_0000; p_in_valid = 1'b1;
      tick();
      p_in_valid = 1'b0;
      chk("mul32", {p_wb_en, p_wb_val, p_psw}, {1'b1, 32'h0, 5'b11100});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
